// File: rtl/custom_pr_controller.sv
// Partial-reconfiguration sequencer for the custom exunit region:
// gates issue on the resident config, else drains, streams the bitstream and resets the region.
module custom_pr_controller #(
    parameter int NUM_CFG       = 4,
    parameter int CFG_ID_W      = 2,
    parameter int ADDR_W        = 16,
    parameter int WORD_W        = 32,
    parameter int PR_RST_CYCLES = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                ex_req_valid,
    input  logic [CFG_ID_W-1:0] ex_req_cfg,
    output logic                ex_grant,
    input  logic                unit_busy,
    input  logic                cfg_wr_en,
    input  logic [CFG_ID_W-1:0] cfg_wr_id,
    input  logic [ADDR_W-1:0]   cfg_wr_base,
    input  logic [ADDR_W-1:0]   cfg_wr_len,
    output logic                bs_rd_en,
    output logic [ADDR_W-1:0]   bs_rd_addr,
    input  logic [WORD_W-1:0]   bs_rd_data,
    output logic                icap_csib,
    output logic [WORD_W-1:0]   icap_wdata,
    output logic                pr_decouple,
    output logic                pr_reset,
    output logic                loaded_valid,
    output logic [CFG_ID_W-1:0] loaded_cfg,
    output logic                pr_error,
    output logic [15:0]         reconfig_count
);

    localparam int RW = (PR_RST_CYCLES > 1) ? $clog2(PR_RST_CYCLES) : 1;
    localparam logic [RW-1:0] RST_LAST = RW'(PR_RST_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, DRAIN, LOAD, PRRST} state_t;

    state_t state, state_nx;

    logic [ADDR_W-1:0]   base_tab [NUM_CFG];
    logic [ADDR_W-1:0]   len_tab  [NUM_CFG];
    logic [CFG_ID_W-1:0] target;
    logic [ADDR_W-1:0]   ld_base;
    logic [ADDR_W-1:0]   ld_len;
    logic [ADDR_W-1:0]   cnt;
    logic [RW-1:0]       rst_cnt;
    logic                req_hit;
    logic                req_miss;
    logic [ADDR_W-1:0]   req_len;
    logic                go_drain;
    logic                go_load;
    logic                go_prrst;
    logic                go_idle;

    assign req_len  = len_tab[ex_req_cfg];
    assign req_hit  = ex_req_valid && loaded_valid && (ex_req_cfg == loaded_cfg);
    assign req_miss = ex_req_valid && !req_hit;

    always_comb begin
        state_nx = state;
        ex_grant = 1'b0;
        pr_error = 1'b0;
        go_drain = 1'b0;
        go_load  = 1'b0;
        go_prrst = 1'b0;
        go_idle  = 1'b0;
        unique case (state)
            IDLE: begin
                ex_grant = req_hit;
                if (req_miss && req_len == '0) begin
                    pr_error = 1'b1;
                end else if (req_miss) begin
                    go_drain = 1'b1;
                    state_nx = DRAIN;
                end
            end
            DRAIN: begin
                if (!ex_req_valid) begin
                    state_nx = IDLE;
                end else if (!unit_busy) begin
                    go_load  = 1'b1;
                    state_nx = LOAD;
                end
            end
            LOAD: begin
                // cnt runs one past the last read so the lagging write completes
                if (cnt == ld_len) begin
                    go_prrst = 1'b1;
                    state_nx = PRRST;
                end
            end
            PRRST: begin
                if (rst_cnt == RST_LAST) begin
                    go_idle  = 1'b1;
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    assign bs_rd_en    = (state == LOAD) && (cnt < ld_len);
    assign bs_rd_addr  = bs_rd_en ? ld_base + cnt : '0;
    assign icap_csib   = !((state == LOAD) && (cnt != '0));
    assign icap_wdata  = icap_csib ? '0 : bs_rd_data;
    assign pr_decouple = (state == LOAD) || (state == PRRST);
    assign pr_reset    = (state == PRRST);

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_CFG; i++) begin
                base_tab[i] <= '0;
                len_tab[i]  <= '0;
            end
        end else if (cfg_wr_en) begin
            base_tab[cfg_wr_id] <= cfg_wr_base;
            len_tab[cfg_wr_id]  <= cfg_wr_len;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            target         <= '0;
            ld_base        <= '0;
            ld_len         <= '0;
            cnt            <= '0;
            rst_cnt        <= '0;
            loaded_valid   <= 1'b0;
            loaded_cfg     <= '0;
            reconfig_count <= '0;
        end else begin
            state   <= state_nx;
            cnt     <= (state == LOAD && !go_prrst) ? cnt + 1'b1 : '0;
            rst_cnt <= (state == PRRST && !go_idle) ? rst_cnt + 1'b1 : '0;
            if (go_drain) begin
                target <= ex_req_cfg;
            end
            if (go_load) begin
                ld_base      <= base_tab[target];
                ld_len       <= len_tab[target];
                loaded_valid <= 1'b0;
            end
            if (go_idle) begin
                loaded_valid <= 1'b1;
                loaded_cfg   <= target;
                if (reconfig_count != 16'hFFFF) begin
                    reconfig_count <= reconfig_count + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_custom_pr_controller.sv
// Scoreboard bench for custom_pr_controller: stimulus queues expected events,
// a negedge monitor pops and compares them as the DUT produces them.
module tb_custom_pr_controller;

    logic        clk = 1'b0;
    logic        reset;
    logic        ex_req_valid;
    logic [1:0]  ex_req_cfg;
    logic        ex_grant;
    logic        unit_busy;
    logic        cfg_wr_en;
    logic [1:0]  cfg_wr_id;
    logic [15:0] cfg_wr_base;
    logic [15:0] cfg_wr_len;
    logic        bs_rd_en;
    logic [15:0] bs_rd_addr;
    logic [31:0] bs_rd_data;
    logic        icap_csib;
    logic [31:0] icap_wdata;
    logic        pr_decouple;
    logic        pr_reset;
    logic        loaded_valid;
    logic [1:0]  loaded_cfg;
    logic        pr_error;
    logic [15:0] reconfig_count;

    custom_pr_controller dut (
        .clk(clk), .reset(reset),
        .ex_req_valid(ex_req_valid), .ex_req_cfg(ex_req_cfg),
        .ex_grant(ex_grant), .unit_busy(unit_busy),
        .cfg_wr_en(cfg_wr_en), .cfg_wr_id(cfg_wr_id),
        .cfg_wr_base(cfg_wr_base), .cfg_wr_len(cfg_wr_len),
        .bs_rd_en(bs_rd_en), .bs_rd_addr(bs_rd_addr),
        .bs_rd_data(bs_rd_data), .icap_csib(icap_csib),
        .icap_wdata(icap_wdata), .pr_decouple(pr_decouple),
        .pr_reset(pr_reset), .loaded_valid(loaded_valid),
        .loaded_cfg(loaded_cfg), .pr_error(pr_error),
        .reconfig_count(reconfig_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          c;
        logic [31:0] v;
    } ev_t;

    ev_t q_rd[$];
    ev_t q_wr[$];
    ev_t q_prr[$];
    ev_t q_gnt[$];
    ev_t q_err[$];

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;
    bit mon_en = 1'b0;

    function automatic logic [31:0] memf(input logic [15:0] a);
        return {~a, a};
    endfunction

    always @(posedge clk) begin
        cyc        <= cyc + 1;
        bs_rd_data <= bs_rd_en ? memf(bs_rd_addr) : 32'h0;
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)",
                      name, act, exp, cyc);
    endtask

    task automatic unexp(input string name, input logic [31:0] act);
        n_chk++;
        $display("FAIL %s: unexpected event value %h (cycle %0d)",
                 name, act, cyc);
    endtask

    always @(negedge clk) begin
        ev_t e;
        if (mon_en) begin
            if (bs_rd_en) begin
                if (q_rd.size() == 0) unexp("rd", {16'h0, bs_rd_addr});
                else begin
                    e = q_rd.pop_front();
                    chk("rd_cyc", cyc, e.c);
                    chk("rd_addr", {16'h0, bs_rd_addr}, e.v);
                end
            end
            if (!icap_csib) begin
                if (q_wr.size() == 0) unexp("wr", icap_wdata);
                else begin
                    e = q_wr.pop_front();
                    chk("wr_cyc", cyc, e.c);
                    chk("wr_data", icap_wdata, e.v);
                end
            end
            if (pr_reset) begin
                if (q_prr.size() == 0) unexp("prr", 32'(pr_decouple));
                else begin
                    e = q_prr.pop_front();
                    chk("prr_cyc", cyc, e.c);
                    chk("prr_dec_lv", {30'h0, pr_decouple, loaded_valid}, e.v);
                end
            end
            if (ex_grant) begin
                if (q_gnt.size() == 0) unexp("gnt", {14'h0, loaded_cfg, reconfig_count});
                else begin
                    e = q_gnt.pop_front();
                    chk("gnt_cyc", cyc, e.c);
                    chk("gnt_state", {13'h0, pr_decouple, loaded_cfg, reconfig_count}, e.v);
                end
            end
            if (pr_error) begin
                if (q_err.size() == 0) unexp("err", 32'(ex_grant));
                else begin
                    e = q_err.pop_front();
                    chk("err_cyc", cyc, e.c);
                    chk("err_grant", 32'(ex_grant), e.v);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic tbl_wr(input logic [1:0] id, input logic [15:0] base,
                          input logic [15:0] len);
        cfg_wr_en   = 1'b1;
        cfg_wr_id   = id;
        cfg_wr_base = base;
        cfg_wr_len  = len;
        tick();
        cfg_wr_en   = 1'b0;
    endtask

    // s = cycle in which the controller is in IDLE with the miss request
    task automatic exp_load(input int s, input logic [15:0] base,
                            input int len, input logic [1:0] cfg,
                            input logic [15:0] cnt);
        logic [15:0] a;
        for (int i = 0; i < len; i++) begin
            a = base + 16'(i);
            q_rd.push_back('{s + 2 + i, {16'h0, a}});
            q_wr.push_back('{s + 3 + i, memf(a)});
        end
        for (int i = 0; i < 4; i++) q_prr.push_back('{s + 3 + len + i, 32'h2});
        q_gnt.push_back('{s + 7 + len, {13'h0, 1'b0, cfg, cnt}});
    endtask

    task automatic wait_grant(input string name);
        bit seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            seen = ex_grant;
        end
        if (!seen) begin
            n_chk++;
            $display("FAIL %s: no grant within 40 cycles (cycle %0d)", name, cyc);
        end
        tick();
        ex_req_valid = 1'b0;
    endtask

    initial begin
        int s;
        reset = 1'b1; ex_req_valid = 1'b0; ex_req_cfg = '0; unit_busy = 1'b0;
        cfg_wr_en = 1'b0; cfg_wr_id = '0; cfg_wr_base = '0; cfg_wr_len = '0;
        tick(); tick();
        reset = 1'b0;
        mon_en = 1'b1;
        @(negedge clk);
        chk("rst_outs", {ex_grant, bs_rd_en, icap_csib, pr_decouple, pr_reset,
                         loaded_valid, pr_error}, 32'h10);
        chk("rst_addr_data", {bs_rd_addr, icap_wdata[15:0]}, 32'h0);
        chk("rst_cfg_cnt", {loaded_cfg, reconfig_count}, 32'h0);

        // full load of cfg 1
        tbl_wr(2'd1, 16'h0100, 16'd3);
        s = cyc; ex_req_valid = 1'b1; ex_req_cfg = 2'd1;
        exp_load(s, 16'h0100, 3, 2'd1, 16'd1);
        wait_grant("load1");

        // resident hit
        tick();
        s = cyc; ex_req_valid = 1'b1; ex_req_cfg = 2'd1;
        q_gnt.push_back('{s, {13'h0, 1'b0, 2'd1, 16'd1}});
        wait_grant("hit1");

        // drain with a busy unit
        tbl_wr(2'd2, 16'h0200, 16'd2);
        s = cyc; unit_busy = 1'b1; ex_req_valid = 1'b1; ex_req_cfg = 2'd2;
        exp_load(s + 4, 16'h0200, 2, 2'd2, 16'd2);
        repeat (5) begin
            @(negedge clk);
            chk("drain_decouple", 32'(pr_decouple), 32'h0);
            tick();
        end
        unit_busy = 1'b0;
        wait_grant("drain2");

        // squash during drain
        tbl_wr(2'd3, 16'h0300, 16'd2);
        unit_busy = 1'b1; ex_req_valid = 1'b1; ex_req_cfg = 2'd3;
        tick(); tick();
        ex_req_valid = 1'b0; unit_busy = 1'b0;
        repeat (4) tick();
        @(negedge clk);
        chk("squash_state", {13'h0, loaded_valid, pr_decouple, loaded_cfg, reconfig_count},
            {13'h0, 1'b1, 1'b0, 2'd2, 16'd2});

        // address wrap
        tbl_wr(2'd3, 16'hFFFE, 16'd3);
        s = cyc; ex_req_valid = 1'b1; ex_req_cfg = 2'd3;
        exp_load(s, 16'hFFFE, 3, 2'd3, 16'd3);
        wait_grant("wrap3");

        // zero-length entry
        s = cyc; ex_req_valid = 1'b1; ex_req_cfg = 2'd0;
        for (int i = 0; i < 3; i++) q_err.push_back('{s + i, 32'h0});
        tick(); tick(); tick();
        ex_req_valid = 1'b0;
        tick();

        // reset during load
        tbl_wr(2'd1, 16'h0100, 16'd3);
        s = cyc; ex_req_valid = 1'b1; ex_req_cfg = 2'd1;
        q_rd.push_back('{s + 2, 32'h0100});
        q_rd.push_back('{s + 3, 32'h0101});
        q_wr.push_back('{s + 3, memf(16'h0100)});
        tick(); tick(); tick();
        reset = 1'b1; ex_req_valid = 1'b0;
        tick();
        reset = 1'b0;
        @(negedge clk);
        chk("midrst_outs", {bs_rd_en, icap_csib, pr_decouple, pr_reset, loaded_valid},
            32'h08);
        chk("midrst_cfg_cnt", {loaded_cfg, reconfig_count}, 32'h0);
        tick();
        tbl_wr(2'd1, 16'h0100, 16'd3);
        s = cyc; ex_req_valid = 1'b1; ex_req_cfg = 2'd1;
        exp_load(s, 16'h0100, 3, 2'd1, 16'd1);
        wait_grant("reload1");

        repeat (5) tick();
        chk("q_rd_left", q_rd.size(), 0);
        chk("q_wr_left", q_wr.size(), 0);
        chk("q_prr_left", q_prr.size(), 0);
        chk("q_gnt_left", q_gnt.size(), 0);
        chk("q_err_left", q_err.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/custom_pr_controller.md
Name: custom_pr_controller

Overview:
Sequences partial reconfiguration of the custom-logic execution unit's reconfigurable region. Sits between the custom-unit issue stage and the custom exunit. Grants issue only when the requested configuration is resident. Otherwise it drains in-flight ops, streams the bitstream from bitstream memory into the configuration port, pulses a region reset, and then releases issue.

Parameters:
NUM_CFG, 4, number of configuration slots in the bitstream table
CFG_ID_W, 2, width of configuration id (log2 NUM_CFG)
ADDR_W, 16, bitstream memory word-address width
WORD_W, 32, configuration word width
PR_RST_CYCLES, 4, cycles pr_reset is held after load (must be >=1)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
ex_req_valid  in  1  issue stage has a custom op ready
ex_req_cfg  in  CFG_ID_W  configuration the op requires
ex_grant  out  1  op may issue this cycle (combinational)
unit_busy  in  1  custom exunit has an op in flight
cfg_wr_en  in  1  write bitstream table entry
cfg_wr_id  in  CFG_ID_W  entry index
cfg_wr_base  in  ADDR_W  first word address of bitstream
cfg_wr_len  in  ADDR_W  bitstream length in words (0 = invalid)
bs_rd_en  out  1  bitstream memory read strobe
bs_rd_addr  out  ADDR_W  read address
bs_rd_data  in  WORD_W  read data, valid 1 cycle after bs_rd_en
icap_csib  out  1  config port enable, active low
icap_wdata  out  WORD_W  config port write word
pr_decouple  out  1  isolate reconfigurable region
pr_reset  out  1  reset reconfigurable region
loaded_valid  out  1  loaded_cfg is resident
loaded_cfg  out  CFG_ID_W  resident configuration id
pr_error  out  1  1-cycle pulse: request for zero-length entry
reconfig_count  out  16  completed reconfigurations, saturating

Behaviour:
- Reset: state IDLE. ex_grant=0, bs_rd_en=0, bs_rd_addr=0, icap_csib=1, icap_wdata=0, pr_decouple=0, pr_reset=0, loaded_valid=0, loaded_cfg=0, pr_error=0, reconfig_count=0. All table entries are base=0, len=0.
- Reset during any state aborts the sequence. loaded_valid=0, so the next request forces a full reload.
- Table writes take effect the next cycle, in any state. Base/len are snapshotted on the DRAIN->LOAD transition, so a write during LOAD affects only later loads.
- IDLE, hit: ex_req_valid, loaded_valid and ex_req_cfg==loaded_cfg. ex_grant=1 in the same cycle. ex_grant is 0 in every other state and condition.
- IDLE, miss, len==0: pr_error pulses 1 cycle. Remain in IDLE; no grant. Pulses again on every cycle the request persists.
- IDLE, miss, len!=0: latch target=ex_req_cfg and go to DRAIN.
- DRAIN, ex_req_valid=0 (squash): return to IDLE; no load, resident config unchanged.
- DRAIN, ex_req_valid=1 and unit_busy=0: go to LOAD. Set pr_decouple=1 and loaded_valid=0 in the same edge, and snapshot base/len.
- LOAD read side: bs_rd_en=1 for exactly len consecutive cycles, with bs_rd_addr=base+i for i=0..len-1, modulo 2^ADDR_W (wraps).
- LOAD write side: icap_csib=0 with icap_wdata=bs_rd_data for exactly len consecutive cycles, lagging the reads by 1 cycle.
- LOAD is not abortable by request withdrawal.
- After the last icap write cycle: go to PRRST. pr_reset=1 for PR_RST_CYCLES cycles; pr_decouple stays 1.
- PRRST exit: on the edge leaving PRRST, pr_reset=0, pr_decouple=0, loaded_cfg=target, loaded_valid=1, reconfig_count+=1 (saturating at 0xFFFF). Then go to IDLE; a hit can be granted the following cycle.
- Total miss latency, with unit idle, is 1 (IDLE) + 1 (DRAIN) + len + 1 + PR_RST_CYCLES cycles to the grant cycle.

Test Plan:
- Load cfg 1: base=0x0100, len=3, PR_RST_CYCLES=4, unit idle; hold request cfg=1 -> rd addrs 0x100,0x101,0x102 on consecutive cycles; icap_csib low 3 cycles with the matching data; pr_reset high 4 cycles; loaded_cfg=1, loaded_valid=1; grant; reconfig_count=1.
- Resident hit: second request for cfg 1 -> ex_grant=1 the same cycle; no bs_rd_en; count stays 1.
- Drain: request cfg 2 while unit_busy=1 for 5 cycles -> stays in DRAIN, pr_decouple=0; LOAD starts the cycle after unit_busy falls.
- Squash: drop ex_req_valid during DRAIN -> back to IDLE; loaded_cfg unchanged; no reads.
- Wrap and error: base=0xFFFE, len=3 -> addrs 0xFFFE,0xFFFF,0x0000. Request for a len=0 entry -> pr_error pulses; no grant; no reads.
- Reset during LOAD -> all outputs at reset values next cycle; next request reloads fully.
